ctrl_pipe: RTL

//   Downstream consumer of the opcode decoder's control word. Carries the
//   per-instruction control bits through ID/EX, EX/MEM and MEM/WB. Also holds
//   the pipeline hazard logic:
//   - load-use stall detection
//   - branch flush
//   - EX-stage operand forwarding selects

---
 rtl/ctrl_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// Carries decoded control bits through the ID/EX, EX/MEM and MEM/WB stages.
// Also generates the hazard signals: load-use stall, branch flush and EX operand forwarding selects.
module ctrl_pipe #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               id_RegDst,
    input  logic               id_ALUSrc,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               id_Branch,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_MemToReg,
    input  logic               id_RegWrite,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               ex_zero,
    output logic               stall,
    output logic               flush,
    output logic               ex_valid,
    output logic               ex_RegDst,
    output logic               ex_ALUSrc,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_wreg,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               mem_valid,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic [REG_W-1:0]   mem_wreg,
    output logic               wb_valid,
    output logic               wb_RegWrite,
    output logic               wb_MemToReg,
    output logic [REG_W-1:0]   wb_wreg
);

    logic ex_Branch, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegWrite;
    logic mem_RegWrite, mem_MemToReg;
    logic load_use, bubble;
    logic mem_fwd_ok, wb_fwd_ok;

    // Every term is ANDed with a valid-gated bit, so X on RegDst/MemToReg never leaks out.
    always_comb begin
        flush    = ex_valid & ex_Branch & ex_zero;
        load_use = id_valid & ex_valid & ex_MemRead & (ex_wreg != '0)
                 & ((ex_wreg == id_rs) | (ex_wreg == id_rt));
        stall    = load_use & ~flush;
    end

    assign bubble     = stall | flush | ~id_valid;
    assign mem_fwd_ok = mem_valid & mem_RegWrite & (mem_wreg != '0);
    assign wb_fwd_ok  = wb_valid & wb_RegWrite & (wb_wreg != '0);

    // NOTE: defaults first so no path through the block leaves fwd_* unassigned (no latch).
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_fwd_ok && mem_wreg == ex_rs)     fwd_a = 2'b10;
        else if (wb_fwd_ok && wb_wreg == ex_rs)  fwd_a = 2'b01;
        if (mem_fwd_ok && mem_wreg == ex_rt)     fwd_b = 2'b10;
        else if (wb_fwd_ok && wb_wreg == ex_rt)  fwd_b = 2'b01;
    end

    // NOTE: non-blocking assignments let every stage sample the previous stage's old value on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_RegDst    <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_ALUOp     <= '0;
            ex_Branch    <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_MemToReg  <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_wreg      <= '0;
            mem_valid    <= 1'b0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_RegWrite <= 1'b0;
            mem_MemToReg <= 1'b0;
            mem_wreg     <= '0;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_MemToReg  <= 1'b0;
            wb_wreg      <= '0;
        end else begin
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_RegDst   <= 1'b0;
                ex_ALUSrc   <= 1'b0;
                ex_ALUOp    <= '0;
                ex_Branch   <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_MemToReg <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_wreg     <= '0;
            end else begin
                ex_valid    <= 1'b1;
                ex_RegDst   <= id_RegDst;
                ex_ALUSrc   <= id_ALUSrc;
                ex_ALUOp    <= id_ALUOp;
                ex_Branch   <= id_Branch & id_valid;
                ex_MemRead  <= id_MemRead & id_valid;
                ex_MemWrite <= id_MemWrite & id_valid;
                ex_MemToReg <= id_MemToReg;
                ex_RegWrite <= id_RegWrite & id_valid;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_wreg     <= id_RegDst ? id_rd : id_rt;
            end
            mem_valid    <= ex_valid;
            mem_MemRead  <= ex_MemRead;
            mem_MemWrite <= ex_MemWrite;
            mem_RegWrite <= ex_RegWrite;
            mem_MemToReg <= ex_MemToReg;
            mem_wreg     <= ex_wreg;
            wb_valid     <= mem_valid;
            wb_RegWrite  <= mem_RegWrite;
            wb_MemToReg  <= mem_MemToReg;
            wb_wreg      <= mem_wreg;
        end
    end

endmodule
